// File: rtl/loop_deglitch_qual.sv
// Deglitch/qualification stage feeding the loop-control digital buffer.
// Synchronises i_raw, qualifies rise/fall with separate windows, reports aborted windows.
module loop_deglitch_qual #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 6,
  parameter int RISE_CNT    = 8,
  parameter int FALL_CNT    = 4,
  parameter int GCNT_W      = 8
) (
  input  logic              CELCLK,
  input  logic              CELRSTN,
  input  logic              CELV,
  input  logic              CELG,
  input  logic              SUB,
  input  logic              en,
  input  logic              i_raw,
  output logic              o,
  output logic              glitch,
  output logic [GCNT_W-1:0] glitch_cnt,
  input  logic              glitch_clr,
  output logic [1:0]        dbg_state_o,
  output logic [CNT_W-1:0]  dbg_cnt_o
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      RISE_CNT < 1 || RISE_CNT > (2**CNT_W) - 1 ||
      FALL_CNT < 1 || FALL_CNT > (2**CNT_W) - 1 ||
      GCNT_W < 1) begin : g_param_check
    $error("loop_deglitch_qual: parameter out of range for CNT_W/SYNC_STAGES");
  end

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    RISE_Q = 2'd1,
    HIGH   = 2'd2,
    FALL_Q = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0]  RISE_C   = CNT_W'(RISE_CNT);
  localparam logic [CNT_W-1:0]  FALL_C   = CNT_W'(FALL_CNT);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [GCNT_W-1:0] GCNT_MAX = '1;

  // Power/substrate pins exist only for netlisting.
  logic unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   o_q, o_d;
  logic                   glitch_q, glitch_d;
  logic [GCNT_W-1:0]      gcnt_q, gcnt_d;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], i_raw};
  assign s       = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CNT_ONE;

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      sync_q   <= '0;
      state_q  <= LOW;
      cnt_q    <= '0;
      o_q      <= 1'b0;
      glitch_q <= 1'b0;
      gcnt_q   <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      o_q      <= o_d;
      glitch_q <= glitch_d;
      gcnt_q   <= gcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = 1'b0;
    if (!en) begin
      state_d = LOW;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LOW: begin
          cnt_d = '0;
          if (s) begin
            if (RISE_C == CNT_ONE) begin
              state_d = HIGH;
            end else begin
              state_d = RISE_Q;
              cnt_d   = CNT_ONE;
            end
          end
        end
        RISE_Q: begin
          if (s) begin
            if (cnt_inc == RISE_C) begin
              state_d = HIGH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d  = LOW;
            cnt_d    = '0;
            glitch_d = 1'b1;
          end
        end
        HIGH: begin
          cnt_d = '0;
          if (!s) begin
            if (FALL_C == CNT_ONE) begin
              state_d = LOW;
            end else begin
              state_d = FALL_Q;
              cnt_d   = CNT_ONE;
            end
          end
        end
        FALL_Q: begin
          if (!s) begin
            if (cnt_inc == FALL_C) begin
              state_d = LOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d  = HIGH;
            cnt_d    = '0;
            glitch_d = 1'b1;
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // o follows the next state so it changes on the same edge as the transition.
  always_comb begin
    o_d = (state_d == HIGH) || (state_d == FALL_Q);
  end

  // Clear has priority over a coincident glitch increment.
  always_comb begin
    gcnt_d = gcnt_q;
    if (glitch_clr) begin
      gcnt_d = '0;
    end else if (glitch_d && (gcnt_q != GCNT_MAX)) begin
      gcnt_d = gcnt_q + GCNT_W'(1);
    end
  end

  assign o           = o_q;
  assign glitch      = glitch_q;
  assign glitch_cnt  = gcnt_q;
  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

endmodule
